audio_adc_capture: RTL and testbench

AUDIO_ADC_CAPTURE -- requirements
Module: audio_adc_capture

---
 rtl/audio_adc_capture.sv | 158 +++++++++++++++
 tb/tb_audio_adc_capture.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/audio_adc_capture.sv
// Audio ADC capture: deserializes a left-justified I2S-style codec ADC stream
// (BCLK/LRCK/DATA, all asynchronous to clk) into one parallel word per
// half-frame. Each word goes to a downstream FIFO as a single-cycle write
// strobe. Sticky flags record words dropped on FIFO-full and short half-frames.
//
// Pipeline, counted from the cycle the codec pins change:
//   p0/p1  two-flop synchronizers
//   p2     delayed copy, used for edge detection; the shift register
//          captures a bit here
//   p3     completed word waiting to be written
//   out    FIFO strobe, data, channel and flags
module audio_adc_capture #(
  parameter int   DATA_WIDTH = 16,
  parameter logic LEFT_LEVEL = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  audio_bclk,
  input  logic                  audio_adclrck,
  input  logic                  audio_adcdat,
  input  logic                  fifo_full,
  input  logic                  clear_flags,
  output logic                  fifo_wrreq,
  output logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_channel,
  output logic                  overflow,
  output logic                  frame_err
);

  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, ARMED, SHIFT, HOLD} state_t;

  state_t                  state;
  logic                    bclk_p0, bclk_p1, bclk_p2;
  logic                    lrck_p0, lrck_p1, lrck_p2;
  logic                    dat_p0, dat_p1;
  logic                    vld_p0, vld_p1, vld_p2;
  logic [DATA_WIDTH-1:0]   shift_reg;
  logic [CNT_W-1:0]        bit_cnt;
  logic                    chan;
  logic                    vld_p3;
  logic [DATA_WIDTH-1:0]   word_p3;
  logic                    chan_p3;
  logic                    bclk_rise;
  logic                    lrck_edge;
  logic                    last_bit;
  logic [DATA_WIDTH-1:0]   shift_next;

  // Synchronizer flops, plus a priming chain. The priming chain keeps the
  // reset value of the delay flop from being seen as a pin edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bclk_p0 <= 1'b0;
      bclk_p1 <= 1'b0;
      bclk_p2 <= 1'b0;
      lrck_p0 <= 1'b0;
      lrck_p1 <= 1'b0;
      lrck_p2 <= 1'b0;
      dat_p0  <= 1'b0;
      dat_p1  <= 1'b0;
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
    end else begin
      bclk_p0 <= audio_bclk;
      bclk_p1 <= bclk_p0;
      bclk_p2 <= bclk_p1;
      lrck_p0 <= audio_adclrck;
      lrck_p1 <= lrck_p0;
      lrck_p2 <= lrck_p1;
      dat_p0  <= audio_adcdat;
      dat_p1  <= dat_p0;
      vld_p0  <= 1'b1;
      vld_p1  <= vld_p0;
      vld_p2  <= vld_p1;
    end
  end

  // ---- p2: edge detection on synchronized codec clocks ----
  always_comb begin
    bclk_rise  = vld_p2 && bclk_p1 && !bclk_p2;
    lrck_edge  = vld_p2 && (lrck_p1 != lrck_p2);
    last_bit   = (bit_cnt == CNT_W'(DATA_WIDTH - 1));
    shift_next = {shift_reg[DATA_WIDTH-2:0], dat_p1};
  end

  // Capture FSM. An LRCK edge always wins over a BCLK rise in the same
  // cycle; that coincident bit becomes the MSB of the new word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      chan      <= 1'b0;
      vld_p3    <= 1'b0;
      word_p3   <= '0;
      chan_p3   <= 1'b0;
    end else begin
      vld_p3 <= 1'b0;
      if (!enable) begin
        state     <= IDLE;
        shift_reg <= '0;
        bit_cnt   <= '0;
      end else begin
        case (state)
          IDLE: state <= ARMED;
          ARMED, SHIFT, HOLD: begin
            if (lrck_edge) begin
              state <= SHIFT;
              chan  <= (lrck_p1 == LEFT_LEVEL);
              if (bclk_rise) begin
                shift_reg <= {{(DATA_WIDTH-1){1'b0}}, dat_p1};
                bit_cnt   <= CNT_W'(1);
              end else begin
                shift_reg <= '0;
                bit_cnt   <= '0;
              end
            end else if (state == SHIFT && bclk_rise) begin
              shift_reg <= shift_next;
              bit_cnt   <= bit_cnt + CNT_W'(1);
              if (last_bit) begin
                // ---- p3: word complete, hand it to the write stage ----
                state   <= HOLD;
                vld_p3  <= 1'b1;
                word_p3 <= shift_next;
                chan_p3 <= chan;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // ---- out: FIFO strobe and sticky flags; a same-cycle set beats clear ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_wrreq   <= 1'b0;
      fifo_data    <= '0;
      fifo_channel <= 1'b0;
      overflow     <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      fifo_wrreq <= vld_p3 && !fifo_full;
      if (vld_p3 && !fifo_full) begin
        fifo_data    <= word_p3;
        fifo_channel <= chan_p3;
      end
      overflow  <= (vld_p3 && fifo_full) || (overflow && !clear_flags);
      frame_err <= (enable && lrck_edge && state == SHIFT) ||
                   (frame_err && !clear_flags);
    end
  end

endmodule

// File: tb/tb_audio_adc_capture.sv
// Bench for audio_adc_capture. Directed codec half-frames are driven with
// hand-chosen words. Expected FIFO writes are queued as stimulus is issued,
// and a monitor checks every strobe against that queue.
module tb_audio_adc_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        audio_bclk = 1'b0;
  logic        audio_adclrck = 1'b0;
  logic        audio_adcdat = 1'b0;
  logic        fifo_full = 1'b0;
  logic        clear_flags = 1'b0;
  logic        fifo_wrreq;
  logic [15:0] fifo_data;
  logic        fifo_channel;
  logic        overflow;
  logic        frame_err;

  typedef struct packed {
    logic        ch;
    logic [15:0] d;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   strobes = 0;
  int   cyc = 0;
  int   bit16_cyc = 0;

  audio_adc_capture #(.DATA_WIDTH(16), .LEFT_LEVEL(1'b1)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .audio_bclk   (audio_bclk),
    .audio_adclrck(audio_adclrck),
    .audio_adcdat (audio_adcdat),
    .fifo_full    (fifo_full),
    .clear_flags  (clear_flags),
    .fifo_wrreq   (fifo_wrreq),
    .fifo_data    (fifo_data),
    .fifo_channel (fifo_channel),
    .overflow     (overflow),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe must match the next queued word, 4 clk after the
  // pin rise of its 16th bit.
  always @(negedge clk) begin
    if (reset && fifo_wrreq) begin
      strobes++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe data=%h ch=%b cyc=%0d", fifo_data, fifo_channel, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        checks++;
        if (fifo_data !== mon_e.d) begin
          errors++;
          $display("FAIL strobe_data got=%h exp=%h", fifo_data, mon_e.d);
        end
        checks++;
        if (fifo_channel !== mon_e.ch) begin
          errors++;
          $display("FAIL strobe_channel got=%b exp=%b (word %h)", fifo_channel, mon_e.ch, mon_e.d);
        end
        checks++;
        if (cyc - bit16_cyc != 4) begin
          errors++;
          $display("FAIL strobe_latency got=%0d exp=4 (word %h)", cyc - bit16_cyc, mon_e.d);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // One half-frame at LRCK level lv: nbits BCLK periods, word MSB first in
  // slots 1-16 and zeros after. Optionally pulse clear_flags so that it lands
  // on the same clock edge as the flag update for this word.
  task automatic half_frame(input logic lv, input logic [15:0] w, input int nbits,
                            input bit push, input bit clr_at_done);
    if (push) exp_q.push_back({lv, w});
    audio_adclrck = lv;
    for (int i = 0; i < nbits; i++) begin
      audio_adcdat = (i < 16) ? w[15-i] : 1'b0;
      audio_bclk = 1'b0;
      tick(6);
      audio_bclk = 1'b1;
      if (i == 15) bit16_cyc = cyc;
      if (i == 15 && clr_at_done) begin
        tick(3);
        clear_flags = 1'b1;
        tick(1);
        clear_flags = 1'b0;
        tick(2);
      end else begin
        tick(6);
      end
    end
  endtask

  task automatic pulse_clear();
    clear_flags = 1'b1;
    tick(1);
    clear_flags = 1'b0;
    tick(1);
  endtask

  initial begin
    // Reset state
    tick(3);
    chk("rst_wrreq", {31'd0, fifo_wrreq}, 32'd0);
    chk("rst_data", {16'd0, fifo_data}, 32'd0);
    chk("rst_channel", {31'd0, fifo_channel}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    reset = 1'b1;
    tick(2);
    enable = 1'b1;
    tick(10);

    // Left word 0xA5C3, then a full stereo sequence
    half_frame(1'b1, 16'hA5C3, 32, 1, 0);
    chk("strobes_left", strobes, 1);
    half_frame(1'b0, 16'h0F0F, 32, 1, 0);
    half_frame(1'b1, 16'h8001, 32, 1, 0);
    half_frame(1'b0, 16'h7FFE, 32, 1, 0);
    chk("strobes_stereo", strobes, 4);
    chk("held_data", {16'd0, fifo_data}, 32'h7FFE);
    chk("held_channel", {31'd0, fifo_channel}, 32'd0);

    // FIFO full during the right word; clear coincides with the overflow set
    half_frame(1'b1, 16'h1111, 32, 1, 0);
    fifo_full = 1'b1;
    half_frame(1'b0, 16'h2222, 32, 0, 1);
    fifo_full = 1'b0;
    chk("overflow_set", {31'd0, overflow}, 32'd1);
    half_frame(1'b1, 16'h3333, 32, 1, 0);
    chk("overflow_sticky", {31'd0, overflow}, 32'd1);
    chk("strobes_overflow", strobes, 6);
    pulse_clear();
    chk("overflow_cleared", {31'd0, overflow}, 32'd0);
    chk("frame_err_quiet", {31'd0, frame_err}, 32'd0);

    // Short half-frame of 10 bits, then a clean word 0x1234
    half_frame(1'b0, 16'hFFC0, 10, 0, 0);
    half_frame(1'b1, 16'h1234, 32, 1, 0);
    chk("frame_err_set", {31'd0, frame_err}, 32'd1);
    chk("strobes_frame_err", strobes, 7);
    pulse_clear();
    chk("frame_err_cleared", {31'd0, frame_err}, 32'd0);

    // Enable dropped at bit 8; remaining slots without LRCK edge are ignored
    half_frame(1'b0, 16'h5555, 8, 0, 0);
    enable = 1'b0;
    tick(20);
    enable = 1'b1;
    half_frame(1'b0, 16'hFFFF, 24, 0, 0);
    chk("strobes_enable_drop", strobes, 7);
    half_frame(1'b1, 16'h6666, 32, 1, 0);
    chk("strobes_enable_resume", strobes, 8);
    chk("frame_err_enable", {31'd0, frame_err}, 32'd0);

    // Reset asserted at bit 12
    half_frame(1'b0, 16'h7777, 12, 0, 0);
    reset = 1'b0;
    #1;
    chk("midrst_wrreq", {31'd0, fifo_wrreq}, 32'd0);
    chk("midrst_data", {16'd0, fifo_data}, 32'd0);
    chk("midrst_channel", {31'd0, fifo_channel}, 32'd0);
    chk("midrst_overflow", {31'd0, overflow}, 32'd0);
    chk("midrst_frame_err", {31'd0, frame_err}, 32'd0);
    tick(5);
    reset = 1'b1;
    tick(5);
    half_frame(1'b0, 16'hFFFF, 20, 0, 0);
    chk("strobes_after_reset", strobes, 8);
    half_frame(1'b1, 16'hBEEF, 32, 1, 0);
    half_frame(1'b0, 16'hC001, 32, 1, 0);
    tick(20);
    chk("strobes_total", strobes, 10);
    chk("queue_drained", exp_q.size(), 0);
    chk("final_overflow", {31'd0, overflow}, 32'd0);
    chk("final_frame_err", {31'd0, frame_err}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
